// File: rtl/usb_slave_fifo.sv
// usb_slave_fifo: FX2-class slave-FIFO master that echoes EP2 OUT words back to EP6 IN through a loopback buffer.
// Latency: one setup cycle ahead of each read/write burst; strobes then move one word per clock.
// Backpressure: flaga low or a full buffer ends a read burst; flagd low stalls writes with the word held. Option: USB_PKEND_EN.

module usb_loop_fifo #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          core_clk,
    input  logic          arst_n,
    input  logic          wr_vld,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_rdy,
    output logic [DW-1:0] rd_dat,
    output logic          full,
    output logic          empty
);
    logic [DW-1:0] mem [2**AW];
    logic [AW:0]   wp;
    logic [AW:0]   rp;
    logic          push;
    logic          pop;

    assign push   = wr_vld & ~full;
    assign pop    = rd_rdy & ~empty;
    // Extra wrap bit separates full from empty when the index bits match.
    assign empty  = (wp == rp);
    assign full   = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rd_dat = mem[rp[AW-1:0]];

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + {{AW{1'b0}}, 1'b1};
            if (pop)  rp <= rp + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge core_clk) begin
        if (push) mem[wp[AW-1:0]] <= wr_dat;
    end
endmodule

module usb_slave_fifo #(
    parameter int         BUF_AW = 4,
    parameter logic [1:0] EP_RD  = 2'b00,
    parameter logic [1:0] EP_WR  = 2'b10
) (
    input  logic       i_usb_ifclk,
    input  logic       i_rst_n,
    input  logic       i_usb_flaga,
    input  logic       i_usb_flagd,
    inout  wire [15:0] io_usb_data,
    output logic [1:0] o_usb_addr,
    output logic       o_usb_slrd,
    output logic       o_usb_slwr,
    output logic       o_usb_sloe,
    output logic       o_usb_pkend
);
    typedef enum logic [2:0] {
        IDLE, RD_SETUP, RD, RD_END, WR_SETUP, WR, PKEND
    } state_t;

    state_t      state;
    logic        buf_full;
    logic        buf_empty;
    logic [15:0] buf_head;
    logic        rd_go;
    logic        wr_go;

    // Strobes stay combinational on the flags so a flag drop stops the very next transfer.
    assign rd_go       = (state == RD) & i_usb_flaga & ~buf_full;
    assign wr_go       = (state == WR) & i_usb_flagd & ~buf_empty;
    assign o_usb_slrd  = ~rd_go;
    assign o_usb_slwr  = ~wr_go;
    assign io_usb_data = (state == WR) ? buf_head : 16'hzzzz;

    usb_loop_fifo #(.DW(16), .AW(BUF_AW)) u_loop (
        .core_clk (i_usb_ifclk),
        .arst_n   (i_rst_n),
        .wr_vld   (rd_go),
        .wr_dat   (io_usb_data),
        .rd_rdy   (wr_go),
        .rd_dat   (buf_head),
        .full     (buf_full),
        .empty    (buf_empty)
    );

`ifdef USB_PKEND_EN
    logic pkend_n;
    assign o_usb_pkend = pkend_n;
`else
    assign o_usb_pkend = 1'b1;
`endif

    always_ff @(posedge i_usb_ifclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            o_usb_addr <= EP_RD;
            o_usb_sloe <= 1'b1;
`ifdef USB_PKEND_EN
            pkend_n    <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_usb_flaga && !buf_full) begin
                        state      <= RD_SETUP;
                        o_usb_addr <= EP_RD;
                        o_usb_sloe <= 1'b0;
                    end else if (!buf_empty) begin
                        state      <= WR_SETUP;
                        o_usb_addr <= EP_WR;
                    end
                end
                RD_SETUP: state <= RD;
                RD: begin
                    if (!rd_go) begin
                        state      <= RD_END;
                        o_usb_sloe <= 1'b1;
                    end
                end
                // Turnaround: the chip releases the bus before anything else happens.
                RD_END:   state <= IDLE;
                WR_SETUP: state <= WR;
                WR: begin
                    if (buf_empty) begin
`ifdef USB_PKEND_EN
                        state   <= PKEND;
                        pkend_n <= 1'b0;
`else
                        state   <= IDLE;
`endif
                    end
                end
                PKEND: begin
                    state <= IDLE;
`ifdef USB_PKEND_EN
                    pkend_n <= 1'b1;
`endif
                end
                default: begin
                    state      <= IDLE;
                    o_usb_sloe <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_usb_slave_fifo.sv
// Bench for usb_slave_fifo: a host-side FIFO model feeds EP2, a word-queue scoreboard checks every strobe.
module tb_usb_slave_fifo;
    localparam logic [1:0] EP_RD = 2'b00;
    localparam logic [1:0] EP_WR = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flaga = 1'b0;
    logic        flagd = 1'b0;
    logic        flaga_en = 1'b0;
    logic        flagd_en = 1'b0;
    logic        probe = 1'b1;
    logic [15:0] host_dat = 16'h0000;
    wire  [15:0] usb_data;
    wire         host_oe;
    wire  [15:0] host_val;
    logic [1:0]  addr;
    logic        slrd, slwr, sloe, pkend;

    // Chip drives the bus while sloe is low; otherwise a probe pull-low exposes any stray DUT drive.
    assign host_oe  = ~sloe | probe;
    assign host_val = sloe ? 16'h0000 : host_dat;
    assign usb_data = host_oe ? host_val : 16'hzzzz;

    usb_slave_fifo #(.BUF_AW(4), .EP_RD(EP_RD), .EP_WR(EP_WR)) dut (
        .i_usb_ifclk (clk),
        .i_rst_n     (rst_n),
        .i_usb_flaga (flaga),
        .i_usb_flagd (flagd),
        .io_usb_data (usb_data),
        .o_usb_addr  (addr),
        .o_usb_slrd  (slrd),
        .o_usb_slwr  (slwr),
        .o_usb_sloe  (sloe),
        .o_usb_pkend (pkend)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, cyc = 0;
    int n_rd = 0, n_wr = 0, n_pk = 0, sloe_fall = 0, slrd_fall = 0;
    int base, base_w, base_p;
    logic prev_sloe = 1'b1, prev_slrd = 1'b1;
    logic [1:0] prev_addr = EP_RD;
    logic [15:0] mq[$];
    logic [15:0] ep2[$];
    logic [15:0] wrote[$];
    logic [15:0] sent[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic host_update();
        flaga    = flaga_en && (ep2.size() > 0);
        flagd    = flagd_en;
        host_dat = (ep2.size() > 0) ? ep2[0] : 16'h0000;
    endtask

    // One clock: check outputs at the falling edge, then advance the host after the rising edge.
    task automatic step();
        logic rd;
        @(negedge clk);
        cyc++;
        rd = 1'b0;
        if (!rst_n) mq.delete();
`ifdef USB_PKEND_EN
        if (!pkend) begin
            n_pk++;
            chk("pkend_addr", addr, EP_WR);
            chk("pkend_strobes", {slrd, slwr}, 2'b11);
        end
`else
        chk("pkend_high", pkend, 1'b1);
`endif
        if (addr !== prev_addr) chk("addr_change_strobes", {slrd, slwr}, 2'b11);
        if (!sloe) begin
            chk("oe_bus_not_driven", usb_data, host_dat);
            chk("oe_no_slwr", slwr, 1'b1);
        end
        if (!sloe && prev_sloe) sloe_fall = cyc;
        if (!slrd && prev_slrd) slrd_fall = cyc;
        if (!slrd) begin
            chk("rd_sloe_low", {prev_sloe, sloe}, 2'b00);
            chk("rd_addr", addr, EP_RD);
            chk("rd_flaga", flaga, 1'b1);
            chk("rd_room", mq.size() < 16, 1'b1);
            mq.push_back(usb_data);
            n_rd++;
            rd = 1'b1;
        end
        if (!slwr) begin
            chk("wr_addr", addr, EP_WR);
            chk("wr_flagd", flagd, 1'b1);
            chk("wr_has_data", mq.size() > 0, 1'b1);
            if (mq.size() > 0) begin
                chk("wr_data", usb_data, mq[0]);
                wrote.push_back(mq.pop_front());
            end
            n_wr++;
        end
        prev_sloe = sloe;
        prev_slrd = slrd;
        prev_addr = addr;
        @(posedge clk);
        #1;
        if (rd && ep2.size() > 0) void'(ep2.pop_front());
        host_update();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        host_update();
        repeat (3) step();
        chk("rst_strobes", {slrd, slwr, sloe, pkend}, 4'b1111);
        chk("rst_addr", addr, 2'b00);
        chk("rst_bus", usb_data, 16'h0000);
        rst_n = 1'b1;

        // Idle: 6000 ns with both flags low.
        repeat (600) step();
        chk("idle_strobes", {slrd, slwr, sloe, pkend}, 4'b1111);
        chk("idle_addr", addr, 2'b00);
        chk("idle_bus", usb_data, 16'h0000);
        chk("idle_no_xfer", n_rd + n_wr, 0);

        // Read burst of three words.
        probe = 1'b0;
        ep2.push_back(16'hFFFF); ep2.push_back(16'h1234); ep2.push_back(16'hA5A5);
        flaga_en = 1'b1;
        flagd_en = 1'b0;
        host_update();
        base = n_rd;
        for (int i = 0; i < 40 && ep2.size() > 0; i++) step();
        repeat (6) step();
        chk("rd_count", n_rd - base, 3);
        chk("rd_oe_lead", slrd_fall - sloe_fall, 1);
        chk("rd_buf_words", mq.size(), 3);
        chk("rd_done_slrd", slrd, 1'b1);

        // Write back once EP6 has room.
        flagd_en = 1'b1;
        host_update();
        base_w = n_wr;
        base_p = n_pk;
        wrote.delete();
        for (int i = 0; i < 40 && wrote.size() < 3; i++) step();
        repeat (4) step();
        chk("wb_count", n_wr - base_w, 3);
        chk("wb_w0", wrote[0], 16'hFFFF);
        chk("wb_w1", wrote[1], 16'h1234);
        chk("wb_w2", wrote[2], 16'hA5A5);
        chk("wb_addr", addr, EP_WR);
        chk("wb_done_slwr", slwr, 1'b1);
`ifdef USB_PKEND_EN
        chk("wb_pkend_pulses", n_pk - base_p, 1);
`endif

        // Full buffer: EP2 keeps data, EP6 blocked.
        flagd_en = 1'b0;
        sent.delete();
        for (int i = 0; i < 20; i++) begin
            ep2.push_back(16'h1000 + 16'(i) * 16'h0111);
            sent.push_back(16'h1000 + 16'(i) * 16'h0111);
        end
        flaga_en = 1'b1;
        host_update();
        base = n_rd;
        repeat (40) step();
        chk("full_reads", n_rd - base, 16);
        chk("full_slrd", slrd, 1'b1);
        chk("full_words", mq.size(), 16);
        chk("full_ep2_left", ep2.size(), 4);

        // Backpressure: drop flagd after five writes, then resume.
        wrote.delete();
        flagd_en = 1'b1;
        host_update();
        for (int i = 0; i < 40 && wrote.size() < 5; i++) step();
        flagd_en = 1'b0;
        host_update();
        repeat (4) begin
            step();
            chk("bp_slwr", slwr, 1'b1);
            chk("bp_hold", usb_data, (mq.size() > 0) ? mq[0] : 16'hDEAD);
        end
        flagd_en = 1'b1;
        host_update();
        for (int i = 0; i < 300 && wrote.size() < 20; i++) step();
        chk("bp_total", wrote.size(), 20);
        for (int i = 0; i < 20; i++) chk("bp_order", wrote[i], sent[i]);
        repeat (6) step();

        // Reset while a write is pending.
        flagd_en = 1'b0;
        ep2.push_back(16'h0BAD); ep2.push_back(16'h7E57); ep2.push_back(16'h00C3);
        flaga_en = 1'b1;
        host_update();
        repeat (20) step();
        chk("pre_rst_words", mq.size(), 3);
        flagd_en = 1'b1;
        host_update();
        #1;
        chk("pre_rst_slwr", slwr, 1'b0);
        rst_n = 1'b0;
        probe = 1'b1;
        #1;
        chk("rst_wr_slwr", slwr, 1'b1);
        chk("rst_wr_sloe", sloe, 1'b1);
        chk("rst_wr_addr", addr, EP_RD);
        chk("rst_wr_bus", usb_data, 16'h0000);
        base_w = n_wr;
        repeat (2) step();
        rst_n = 1'b1;
        probe = 1'b0;
        repeat (20) step();
        chk("post_rst_writes", n_wr - base_w, 0);
        chk("post_rst_slwr", slwr, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
